text_writer: RTL and testbench
==============================

TEXT_WRITER -- requirements
Module: text_writer

Interface
REQ-001 SHALL have parameter COLS, default 80, text columns per row.
REQ-002 SHALL have parameter ROWS, default 30, text rows per screen.
REQ-003 SHALL have parameter ATTR_W, default 16, attribute bits per cell (value = {attr, char index}).
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  byte offered.
REQ-007 SHALL have port in_data  input  8  character code.
REQ-008 SHALL have port in_attr  input  ATTR_W  attribute applied to in_data.
REQ-009 SHALL have port in_ready  output  1  byte accepted when in_valid and in_ready are both high at a clock edge.
REQ-010 SHALL have port write  output  1  video memory write strobe.
REQ-011 SHALL have port xtextwrite  output  7  write column.
REQ-012 SHALL have port ytextwrite  output  5  write row.
REQ-013 SHALL have port value  output  ATTR_W+8  write data {attr, char}.
REQ-014 SHALL have port cursor_x  output  7  current cursor column.
REQ-015 SHALL have port cursor_y  output  5  current cursor row.
REQ-016 SHALL have port busy  output  1  high while a clear sweep runs.

Function
REQ-017 SHALL implement states IDLE, CLRROW, CLRALL; in_ready = (state == IDLE); busy = !in_ready.
REQ-018 SHALL register write, xtextwrite, ytextwrite and value; a write caused by an accept at edge N SHALL be visible in cycle N+1.
REQ-019 SHALL treat codes 0x20-0xFF as printable: write {in_attr, in_data} at the cursor; cursor_x increments.
REQ-020 SHALL, for a printable byte accepted at cursor_x = COLS-1, set cursor_x = 0, advance the row, and enter CLRROW after the character write.
REQ-021 SHALL treat 0x0A (LF) as newline: cursor_x = 0; row advances; no character write; enter CLRROW.
REQ-022 SHALL advance rows as y+1, with ROWS-1 wrapping to 0 (no scrolling).
REQ-023 SHALL treat 0x0D (CR) as: cursor_x = 0, no write.
REQ-024 SHALL treat 0x08 (BS) as: cursor_x decrements if nonzero, else no change; no write.
REQ-025 SHALL treat 0x0C (FF) as: enter CLRALL; cursor set to (0,0).
REQ-026 SHALL consume other codes below 0x20 with no write and no cursor change.
REQ-027 SHALL, in CLRROW, write {latched attr, 0x20} to columns 0..COLS-1 of the new cursor row, one per cycle, then return to IDLE.
REQ-028 SHALL, in CLRALL, write {latched attr, 0x20} to all COLS*ROWS cells in row-major order from (0,0), one per cycle, then return to IDLE.
REQ-029 SHALL latch the sweep attribute from in_attr of the triggering byte.
REQ-030 SHALL drive write = 0 in every cycle without a scheduled write; x, y and value hold their previous values.
REQ-031 SHALL keep in_ready low from the cycle after a sweep-triggering accept through the last sweep write cycle.
REQ-032 SHALL support back-to-back accepts of printable, non-wrapping bytes: one write per cycle.

Reset
REQ-033 SHALL, on reset assertion, immediately force state IDLE, cursor (0,0), write 0, xtextwrite 0, ytextwrite 0, value 0 and latched attr 0, including mid-sweep; an interrupted sweep is abandoned and not resumed.
REQ-034 SHALL hold in_ready low while reset is asserted.

Verification
REQ-035 SHALL pass: after reset, accept 'A' (0x41), attr 0x0107 -> cycle N+1: write = 1, (0,0), value 0x010741; cursor (1,0); in_ready stays high.
REQ-036 SHALL pass: cursor (79,3), accept 0x42 -> N+1: write at (79,3); then 80 writes at (0..79,4) with char 0x20; in_ready low for 81 cycles; cursor ends at (0,4).
REQ-037 SHALL pass: cursor (5,29), accept LF -> 80 blank writes to row 0; cursor (0,0); in_ready low for 80 cycles.
REQ-038 SHALL pass: accept FF -> 2400 consecutive writes; the first is at (0,0) and the last at (79,29); busy then falls; cursor (0,0).
REQ-039 SHALL pass: BS at (0,7) -> cursor (0,7), no write; CR at (12,7) -> cursor (0,7); 0x01 -> no change.
REQ-040 SHALL pass: reset asserted during CLRALL at cell 500 -> outputs zero immediately; after release: idle, in_ready = 1, no further writes.

Source files
------------

// File: rtl/text_writer.sv
// Character-stream text writer: turns a byte stream into video memory cell writes,
// handling CR/LF/BS/FF and clearing the fresh row (or whole screen) with blanks. Assumes COLS >= 2.
module text_writer #(
  parameter int COLS   = 80,
  parameter int ROWS   = 30,
  parameter int ATTR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic [ATTR_W-1:0] in_attr,
  output logic              in_ready,
  output logic              write,
  output logic [6:0]        xtextwrite,
  output logic [4:0]        ytextwrite,
  output logic [ATTR_W+7:0] value,
  output logic [6:0]        cursor_x,
  output logic [4:0]        cursor_y,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, CLRROW, CLRALL} state_t;

  localparam logic [6:0] LAST_COL = 7'(COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  state_t            state, state_n;
  logic [6:0]        cursor_x_n, sweep_x, sweep_x_n, xtextwrite_n;
  logic [4:0]        cursor_y_n, sweep_y, sweep_y_n, ytextwrite_n, row_inc;
  logic              sweep_last, sweep_last_n, write_n, accept;
  logic [ATTR_W-1:0] sweep_attr, sweep_attr_n;
  logic [ATTR_W+7:0] value_n, blank;

  assign in_ready = (state == IDLE) && !reset;
  assign busy     = !in_ready;
  assign accept   = in_valid && in_ready;
  assign row_inc  = (cursor_y == LAST_ROW) ? 5'd0 : cursor_y + 5'd1;
  assign blank    = {sweep_attr, 8'h20};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cursor_x   <= '0;
      cursor_y   <= '0;
      sweep_x    <= '0;
      sweep_y    <= '0;
      sweep_last <= 1'b0;
      sweep_attr <= '0;
      write      <= 1'b0;
      xtextwrite <= '0;
      ytextwrite <= '0;
      value      <= '0;
    end else begin
      state      <= state_n;
      cursor_x   <= cursor_x_n;
      cursor_y   <= cursor_y_n;
      sweep_x    <= sweep_x_n;
      sweep_y    <= sweep_y_n;
      sweep_last <= sweep_last_n;
      sweep_attr <= sweep_attr_n;
      write      <= write_n;
      xtextwrite <= xtextwrite_n;
      ytextwrite <= ytextwrite_n;
      value      <= value_n;
    end
  end

  // sweep_last marks that the final blank has been issued; the state is held one
  // more cycle so in_ready stays low while that last write is visible.
  always_comb begin
    state_n      = state;
    cursor_x_n   = cursor_x;
    cursor_y_n   = cursor_y;
    sweep_x_n    = sweep_x;
    sweep_y_n    = sweep_y;
    sweep_last_n = sweep_last;
    sweep_attr_n = sweep_attr;
    write_n      = 1'b0;
    xtextwrite_n = xtextwrite;
    ytextwrite_n = ytextwrite;
    value_n      = value;
    case (state)
      IDLE: begin
        if (accept) begin
          if (in_data >= 8'h20) begin
            write_n      = 1'b1;
            xtextwrite_n = cursor_x;
            ytextwrite_n = cursor_y;
            value_n      = {in_attr, in_data};
            if (cursor_x == LAST_COL) begin
              cursor_x_n   = '0;
              cursor_y_n   = row_inc;
              sweep_x_n    = '0;
              sweep_last_n = 1'b0;
              sweep_attr_n = in_attr;
              state_n      = CLRROW;
            end else begin
              cursor_x_n = cursor_x + 7'd1;
            end
          end else begin
            case (in_data)
              8'h0A: begin
                // Column 0 of the new row is blanked right away so the sweep
                // takes exactly COLS cycles.
                cursor_x_n   = '0;
                cursor_y_n   = row_inc;
                write_n      = 1'b1;
                xtextwrite_n = '0;
                ytextwrite_n = row_inc;
                value_n      = {in_attr, 8'h20};
                sweep_x_n    = 7'd1;
                sweep_last_n = 1'b0;
                sweep_attr_n = in_attr;
                state_n      = CLRROW;
              end
              8'h0D: cursor_x_n = '0;
              8'h08: begin
                if (cursor_x != 7'd0) cursor_x_n = cursor_x - 7'd1;
              end
              8'h0C: begin
                cursor_x_n   = '0;
                cursor_y_n   = '0;
                write_n      = 1'b1;
                xtextwrite_n = '0;
                ytextwrite_n = '0;
                value_n      = {in_attr, 8'h20};
                sweep_x_n    = 7'd1;
                sweep_y_n    = '0;
                sweep_last_n = 1'b0;
                sweep_attr_n = in_attr;
                state_n      = CLRALL;
              end
              default: ;
            endcase
          end
        end
      end
      CLRROW: begin
        if (sweep_last) begin
          state_n = IDLE;
        end else begin
          write_n      = 1'b1;
          xtextwrite_n = sweep_x;
          ytextwrite_n = cursor_y;
          value_n      = blank;
          if (sweep_x == LAST_COL) sweep_last_n = 1'b1;
          else sweep_x_n = sweep_x + 7'd1;
        end
      end
      CLRALL: begin
        if (sweep_last) begin
          state_n = IDLE;
        end else begin
          write_n      = 1'b1;
          xtextwrite_n = sweep_x;
          ytextwrite_n = sweep_y;
          value_n      = blank;
          if (sweep_x == LAST_COL) begin
            sweep_x_n = '0;
            if (sweep_y == LAST_ROW) sweep_last_n = 1'b1;
            else sweep_y_n = sweep_y + 5'd1;
          end else begin
            sweep_x_n = sweep_x + 7'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_text_writer.sv
// Scoreboard bench for text_writer: a cursor model queues every expected cell write,
// and a negedge monitor pops and compares each write the DUT produces.
module tb_text_writer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic [15:0] in_attr = 16'h0000;
  logic        in_ready, write, busy;
  logic [6:0]  xtextwrite, cursor_x;
  logic [4:0]  ytextwrite, cursor_y;
  logic [23:0] value;

  int vectors = 0;
  int miscompares = 0;
  int write_seen = 0;
  logic [35:0] sb[$];
  int mx = 0;
  int my = 0;

  text_writer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_attr(in_attr),
    .in_ready(in_ready), .write(write), .xtextwrite(xtextwrite), .ytextwrite(ytextwrite),
    .value(value), .cursor_x(cursor_x), .cursor_y(cursor_y), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish (got running, required done)");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Every write seen outside reset must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && write) begin
      write_seen++;
      if (sb.size() == 0) checkOutput("unexpected_write", {xtextwrite, ytextwrite, value}, 64'h0);
      else checkOutput("wr_cell", {xtextwrite, ytextwrite, value}, sb.pop_front());
    end
  end

  function automatic int rowInc(input int r);
    return (r == 29) ? 0 : r + 1;
  endfunction

  task automatic pushBlankRow(input int row, input logic [15:0] a);
    for (int c = 0; c < 80; c++) sb.push_back({7'(c), 5'(row), a, 8'h20});
  endtask

  // Updates the cursor model and queues the writes a byte should cause; returns the
  // number of cycles in_ready should stay low afterwards.
  task automatic modelByte(input logic [7:0] d, input logic [15:0] a, output int exp_busy);
    exp_busy = 0;
    if (d >= 8'h20) begin
      sb.push_back({7'(mx), 5'(my), a, d});
      if (mx == 79) begin
        mx = 0;
        my = rowInc(my);
        pushBlankRow(my, a);
        exp_busy = 81;
      end else mx++;
    end else if (d == 8'h0A) begin
      mx = 0;
      my = rowInc(my);
      pushBlankRow(my, a);
      exp_busy = 80;
    end else if (d == 8'h0D) mx = 0;
    else if (d == 8'h08) begin
      if (mx != 0) mx--;
    end else if (d == 8'h0C) begin
      for (int r = 0; r < 30; r++) pushBlankRow(r, a);
      mx = 0;
      my = 0;
      exp_busy = 2400;
    end
  endtask

  task automatic waitReady();
    for (int k = 0; k < 5000 && !in_ready; k++) @(negedge clk);
    if (!in_ready) checkOutput("ready_timeout", 64'(in_ready), 64'h1);
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic [15:0] a);
    int exp_busy;
    int n;
    waitReady();
    in_data = d;
    in_attr = a;
    in_valid = 1'b1;
    modelByte(d, a, exp_busy);
    @(posedge clk);
    #1 in_valid = 1'b0;
    checkOutput("cursor_x", 64'(cursor_x), 64'(mx));
    checkOutput("cursor_y", 64'(cursor_y), 64'(my));
    n = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
    end
    checkOutput("busy_len", 64'(n), 64'(exp_busy));
  endtask

  task automatic burstStimulus(input int count, input logic [15:0] a);
    int exp_busy;
    waitReady();
    for (int i = 0; i < count; i++) begin
      in_data = 8'h61 + 8'(i % 26);
      in_attr = a;
      in_valid = 1'b1;
      modelByte(in_data, a, exp_busy);
      @(posedge clk);
      #1;
      checkOutput("burst_ready", 64'(in_ready), 64'h1);
    end
    in_valid = 1'b0;
    checkOutput("burst_cx", 64'(cursor_x), 64'(mx));
    checkOutput("burst_cy", 64'(cursor_y), 64'(my));
  endtask

  initial begin
    int base;
    #12;
    checkOutput("rst_ready", 64'(in_ready), 64'h0);
    checkOutput("rst_outs", {write, xtextwrite, ytextwrite, value, cursor_x, cursor_y}, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("idle_ready", 64'(in_ready), 64'h1);
    checkOutput("idle_busy", 64'(busy), 64'h0);

    applyStimulus(8'h41, 16'h0107);
    applyStimulus(8'h0A, 16'h0300);
    applyStimulus(8'h0A, 16'h0301);
    applyStimulus(8'h0A, 16'h0302);
    burstStimulus(79, 16'h0203);
    applyStimulus(8'h42, 16'h0444);

    applyStimulus(8'h08, 16'h0001);
    applyStimulus(8'h01, 16'h0001);
    for (int i = 0; i < 3; i++) applyStimulus(8'h30 + 8'(i), 16'h0505);
    applyStimulus(8'h08, 16'h0001);
    applyStimulus(8'hFF, 16'h0606);
    applyStimulus(8'h0D, 16'h0001);

    for (int i = 0; i < 25; i++) applyStimulus(8'h0A, 16'h0700 + 16'(i));
    for (int i = 0; i < 5; i++) applyStimulus(8'h20 + 8'(i), 16'h0808);
    applyStimulus(8'h0A, 16'h0909);

    applyStimulus(8'h0C, 16'h0A0A);

    // Interrupt a full-screen clear partway through.
    waitReady();
    in_data = 8'h0C;
    in_attr = 16'h0B0B;
    in_valid = 1'b1;
    begin
      int eb;
      modelByte(8'h0C, 16'h0B0B, eb);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    base = write_seen;
    for (int k = 0; k < 3000 && write_seen < base + 500; k++) @(negedge clk);
    checkOutput("mid_clear_reached", 64'(write_seen - base), 64'd500);
    #2 reset = 1'b1;
    #1;
    checkOutput("midrst_outs", {write, xtextwrite, ytextwrite, value, cursor_x, cursor_y}, 64'h0);
    checkOutput("midrst_ready", 64'(in_ready), 64'h0);
    sb.delete();
    mx = 0;
    my = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    base = write_seen;
    repeat (20) @(negedge clk);
    checkOutput("post_rst_writes", 64'(write_seen - base), 64'h0);
    checkOutput("post_rst_ready", 64'(in_ready), 64'h1);
    checkOutput("post_rst_cursor", {cursor_x, cursor_y}, 64'h0);

    applyStimulus(8'h5A, 16'h0C0C);
    repeat (3) @(negedge clk);
    checkOutput("sb_empty", 64'(sb.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
